// File: rtl/keccak_round_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keccak_pkg
// Description : Shared constants, types and FSM encoding for the Keccak round
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package keccak_pkg;

    localparam int KECCAK_NR = 24;
    localparam int RC_ADDR_W = 5;

    typedef logic [RC_ADDR_W-1:0] rc_addr_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage : keccak_pkg
`default_nettype wire

// File: rtl/keccak_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : keccak_round_ctrl_if
// Description : Handshake and datapath-control bundle between the round
//               controller and its parent.
// Revision    : 1.0 - initial release
// ============================================================================
interface keccak_round_ctrl_if;
    import keccak_pkg::*;

    logic     start;
    logic     ack;
    logic     abort;
    logic     ready;
    logic     load_en;
    logic     round_en;
    rc_addr_t rc_addr;
    logic     last_round;
    logic     busy;
    logic     done;

    modport master (
        output start, ack, abort,
        input  ready, load_en, round_en, rc_addr, last_round, busy, done
    );

    modport slave (
        input  start, ack, abort,
        output ready, load_en, round_en, rc_addr, last_round, busy, done
    );

endinterface : keccak_round_ctrl_if
`default_nettype wire

// File: rtl/keccak_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : keccak_round_ctrl
// Description : Sequences one Keccak-f permutation (load, NR/UR round cycles,
//               done/ack handshake) and addresses the round-constant ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_round_ctrl
    import keccak_pkg::*;
#(
    parameter int UR = 1,
    parameter int NR = KECCAK_NR
) (
    input  wire logic          clk,
    input  wire logic          rst,
    keccak_round_ctrl_if.slave bus
);

    if ((UR != 1) && (UR != 2) && (UR != 3) && (UR != 4) && (UR != 6)) begin : g_bad_ur
        $error("keccak_round_ctrl: UR must be one of 1, 2, 3, 4, 6");
    end
    if ((UR > NR) || ((NR % UR) != 0)) begin : g_bad_nr
        $error("keccak_round_ctrl: NR must be a multiple of UR and UR <= NR");
    end
    if (NR > (1 << RC_ADDR_W)) begin : g_bad_width
        $error("keccak_round_ctrl: NR does not fit the round-address width");
    end

    localparam rc_addr_t C_STEP = rc_addr_t'(UR);
    localparam rc_addr_t C_LAST = rc_addr_t'(NR - UR);

    logic [1:0] state_q, state_d;
    rc_addr_t   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (bus.start) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    state_d = ST_ROUND;
                    cnt_d   = '0;
                end
                ST_ROUND: begin
                    // The >= guard keeps the counter saturated even if it were corrupted.
                    if (cnt_q >= C_LAST) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + C_STEP;
                    end
                end
                ST_DONE: begin
                    cnt_d = '0;
                    if (bus.ack) state_d = bus.start ? ST_LOAD : ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Only ready looks at an input, so a back-to-back start can ride on ack.
    assign bus.ready      = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.ack);
    assign bus.load_en    = (state_q == ST_LOAD);
    assign bus.round_en   = (state_q == ST_ROUND);
    assign bus.rc_addr    = (state_q == ST_ROUND) ? cnt_q : '0;
    assign bus.last_round = (state_q == ST_ROUND) && (cnt_q == C_LAST);
    assign bus.busy       = (state_q == ST_LOAD) || (state_q == ST_ROUND);
    assign bus.done       = (state_q == ST_DONE);

endmodule : keccak_round_ctrl
`default_nettype wire

// File: tb/tb_keccak_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_keccak_round_ctrl
// Description : Directed self-checking bench for keccak_round_ctrl (UR=1, UR=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_round_ctrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    keccak_round_ctrl_if u_if1 ();
    keccak_round_ctrl_if u_if4 ();

    keccak_round_ctrl #(.UR(1), .NR(24)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1.slave));
    keccak_round_ctrl #(.UR(4), .NR(24)) u_dut4 (.clk(clk), .rst(rst), .bus(u_if4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},      int'(u_if1.ready),      1);
        chk({tag, "_load_en"},    int'(u_if1.load_en),    0);
        chk({tag, "_round_en"},   int'(u_if1.round_en),   0);
        chk({tag, "_rc_addr"},    int'(u_if1.rc_addr),    0);
        chk({tag, "_last_round"}, int'(u_if1.last_round), 0);
        chk({tag, "_busy"},       int'(u_if1.busy),       0);
        chk({tag, "_done"},       int'(u_if1.done),       0);
    endtask

    // Entered one sample after the accepting edge; leaves the UR=1 DUT in DONE.
    task automatic check_perm(input string tag);
        chk({tag, "_load_en"}, int'(u_if1.load_en), 1);
        chk({tag, "_busy"},    int'(u_if1.busy),    1);
        chk({tag, "_ready"},   int'(u_if1.ready),   0);
        for (int i = 0; i < 24; i++) begin
            step();
            chk({tag, "_round_en"}, int'(u_if1.round_en),   1);
            chk({tag, "_rc_addr"},  int'(u_if1.rc_addr),    i);
            chk({tag, "_last"},     int'(u_if1.last_round), (i == 23) ? 1 : 0);
            chk({tag, "_ld_off"},   int'(u_if1.load_en),    0);
        end
        step();
        chk({tag, "_done"},     int'(u_if1.done),     1);
        chk({tag, "_rnd_off"},  int'(u_if1.round_en), 0);
        chk({tag, "_rc_zero"},  int'(u_if1.rc_addr),  0);
        chk({tag, "_not_busy"}, int'(u_if1.busy),     0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        u_if1.start = 1'b0; u_if1.ack = 1'b0; u_if1.abort = 1'b0;
        u_if4.start = 1'b0; u_if4.ack = 1'b0; u_if4.abort = 1'b0;
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b0;
        step();
        chk("idle_ready", int'(u_if1.ready), 1);

        // Basic permutation: load at +1, rounds +2..+25, done at +26
        u_if1.start = 1'b1;
        step();
        u_if1.start = 1'b0;
        check_perm("run1");

        // done held without ack; start must be ignored
        u_if1.start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_done",  int'(u_if1.done),    1);
            chk("hold_noload", int'(u_if1.load_en), 0);
            chk("hold_ready", int'(u_if1.ready),   0);
        end
        u_if1.start = 1'b0;
        u_if1.ack   = 1'b1;
        #1;
        chk("done_ready_eq_ack", int'(u_if1.ready), 1);
        step();
        u_if1.ack = 1'b0;
        chk("ack_idle_done",  int'(u_if1.done),  0);
        chk("ack_idle_ready", int'(u_if1.ready), 1);
        chk("ack_idle_busy",  int'(u_if1.busy),  0);

        // Back-to-back: ack and start together in DONE
        u_if1.start = 1'b1;
        step();
        u_if1.start = 1'b0;
        check_perm("run2");
        u_if1.ack   = 1'b1;
        u_if1.start = 1'b1;
        step();
        u_if1.ack   = 1'b0;
        u_if1.start = 1'b0;
        check_perm("b2b");
        u_if1.ack = 1'b1;
        step();
        u_if1.ack = 1'b0;
        chk("b2b_idle", int'(u_if1.ready), 1);

        // Abort at round 10
        u_if1.start = 1'b1;
        step();
        u_if1.start = 1'b0;
        chk("abort_load", int'(u_if1.load_en), 1);
        for (int i = 0; i < 11; i++) step();
        chk("abort_at_rc10", int'(u_if1.rc_addr), 10);
        u_if1.abort = 1'b1;
        step();
        u_if1.abort = 1'b0;
        chk_reset_vals("abort");
        for (int i = 0; i < 30; i++) begin
            step();
            chk("abort_no_done", int'(u_if1.done), 0);
        end

        // abort outranks start
        u_if1.abort = 1'b1;
        u_if1.start = 1'b1;
        step();
        u_if1.abort = 1'b0;
        u_if1.start = 1'b0;
        chk("abort_prio_load",  int'(u_if1.load_en), 0);
        chk("abort_prio_ready", int'(u_if1.ready),   1);

        u_if1.start = 1'b1;
        step();
        u_if1.start = 1'b0;
        check_perm("post_abort");
        u_if1.ack = 1'b1;
        step();
        u_if1.ack = 1'b0;

        // Reset mid-ROUND, then start on the first edge after reset falls
        u_if1.start = 1'b1;
        step();
        u_if1.start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("rst_at_rc5", int'(u_if1.rc_addr), 5);
        rst = 1'b1;
        step();
        chk_reset_vals("rst_mid");
        rst = 1'b0;
        u_if1.start = 1'b1;
        step();
        u_if1.start = 1'b0;
        check_perm("post_rst");
        u_if1.ack = 1'b1;
        step();
        u_if1.ack = 1'b0;

        // UR=4 instance
        u_if4.start = 1'b1;
        step();
        u_if4.start = 1'b0;
        chk("ur4_load", int'(u_if4.load_en), 1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("ur4_round_en", int'(u_if4.round_en),   1);
            chk("ur4_rc_addr",  int'(u_if4.rc_addr),    i * 4);
            chk("ur4_last",     int'(u_if4.last_round), (i == 5) ? 1 : 0);
        end
        step();
        chk("ur4_done",   int'(u_if4.done),     1);
        chk("ur4_rnd_off", int'(u_if4.round_en), 0);

        // Randomised traffic: round address must stay within 0..23
        for (int i = 0; i < 400; i++) begin
            u_if1.start = 1'($urandom_range(0, 1));
            u_if1.ack   = 1'($urandom_range(0, 1));
            u_if1.abort = ($urandom_range(0, 31) == 0);
            step();
            chk("rand_rc_range", (u_if1.rc_addr <= 5'd23) ? 1 : 0, 1);
            chk("rand_last_rc",  u_if1.last_round ? int'(u_if1.rc_addr) : 23, 23);
        end
        u_if1.start = 1'b0;
        u_if1.ack   = 1'b0;
        u_if1.abort = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_keccak_round_ctrl
`default_nettype wire
